// File: rtl/bl_pkg.sv
// bl_pkg: shared definitions for the backlight zone writer.
//   - bl_state_e : writer FSM state encoding
//   - ADDR_W / GRAY_W / LUMA_W : LED address, gray value and zone luma widths
//   - zone_beat_t : one buffered zone result {addr, luma}
package bl_pkg;
  localparam int ADDR_W = 10;
  localparam int GRAY_W = 16;
  localparam int LUMA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOF   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } bl_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LUMA_W-1:0] luma;
  } zone_beat_t;

  localparam int BEAT_W = $bits(zone_beat_t);
endpackage

// File: rtl/bl_sync_fifo.sv
// bl_sync_fifo: single-clock FIFO with registered full/empty flags.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   flush          drop all contents; a push in the same cycle is kept as
//                  the only entry (it belongs to whatever follows the flush)
//   push, wdata    write side; ignored when full (no push-through on pop)
//   pop, rdata     read side; rdata is the show-ahead head entry
//   full, empty    registered status flags
module bl_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  // Gating uses the registered flags, so a pop never frees room for a
  // same-cycle push when the buffer is full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = (AW+1)'(do_push);
    else       count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= AW'(do_push);
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= wdata;
  end
endmodule

// File: rtl/bl_zone_writer.sv
// bl_zone_writer: buffers per-zone luminance results and writes them as
// gray values into the LED SRAM, one frame of NUM_ZONES zones at a time.
// Build option: define BL_GAMMA_EN to map gray = luma*luma; otherwise the
// luma byte is replicated into both gray bytes. Either way the result is
// floored at MIN_GRAY.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   frame_start           new-frame pulse (aborts an unfinished frame)
//   zone_valid/ready      zone beat handshake, zone_addr/zone_luma payload
//   sdbpflag              frame-start strobe to the SRAM
//   wten/wtaddr/wtdina    SRAM write strobe, address, gray data
//   frame_done            pulse one cycle after the last write of a frame
//   seq_err, frame_err    sticky order / early-frame-start errors
module bl_zone_writer
  import bl_pkg::*;
#(
  parameter int                NUM_ZONES  = 1024,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [GRAY_W-1:0] MIN_GRAY   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              zone_valid,
  output logic              zone_ready,
  input  logic [ADDR_W-1:0] zone_addr,
  input  logic [LUMA_W-1:0] zone_luma,
  output logic              sdbpflag,
  output logic              wten,
  output logic [ADDR_W-1:0] wtaddr,
  output logic [GRAY_W-1:0] wtdina,
  output logic              frame_done,
  output logic              seq_err,
  output logic              frame_err
);
  localparam logic [ADDR_W-1:0] ZC_LAST = ADDR_W'(NUM_ZONES - 1);

  bl_state_e         state, state_nxt;
  logic [ADDR_W-1:0] zcnt;
  logic              fifo_full, fifo_empty;
  logic [BEAT_W-1:0] fifo_rdata;
  zone_beat_t        in_beat, head;
  logic              push, pop, abort;

  function automatic logic [GRAY_W-1:0] map_gray(input logic [LUMA_W-1:0] l);
    logic [GRAY_W-1:0] m;
`ifdef BL_GAMMA_EN
    m = GRAY_W'(l) * GRAY_W'(l);
`else
    m = {l, l};
`endif
    return (m < MIN_GRAY) ? MIN_GRAY : m;
  endfunction

  // Ready is low while reset is held and comes up as soon as it is released.
  assign zone_ready = !fifo_full && !reset;
  assign push       = zone_valid && zone_ready;
  assign in_beat    = '{addr: zone_addr, luma: zone_luma};
  assign head       = zone_beat_t'(fifo_rdata);

  // A frame_start outside IDLE kills the frame: flush, no pop this cycle.
  assign abort    = frame_start && (state != IDLE);
  assign pop      = (state == WRITE) && !fifo_empty && !frame_start;
  assign sdbpflag = (state == SOF);

  bl_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .wdata (in_beat),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SOF;
      SOF:     state_nxt = frame_start ? SOF : WRITE;
      WRITE: begin
        if (frame_start)                     state_nxt = SOF;
        else if (pop && (zcnt == ZC_LAST))   state_nxt = DONE;
      end
      DONE:    state_nxt = frame_start ? SOF : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      zcnt       <= '0;
      wten       <= 1'b0;
      wtaddr     <= '0;
      wtdina     <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      wten  <= pop;
      if (pop) begin
        wtaddr <= head.addr;
        wtdina <= map_gray(head.luma);
      end
      if (state == SOF) zcnt <= '0;
      else if (pop)     zcnt <= zcnt + 1'b1;
      seq_err    <= seq_err | (pop && (head.addr != zcnt));
      frame_err  <= frame_err | abort;
      // The last write is on the wire during DONE, so this lands one later.
      frame_done <= (state == DONE) && !frame_start;
    end
  end
endmodule
